program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Writer side of the instruction memory that the stack processor fetches from. Receives a
//  framed byte stream (valid/ready) and writes 16-bit words into port A of instruction memory.
//  Holds the processor in reset while loading and releases it only after a good checksum.
//  Sits between the host byte link (e.g. UART RX) and the inst_memory write port.
// PARAMETERS
//  ADDR_W      12    word-address width; matches the instruction memory addra (pc[12:1])
//  MAX_WORDS   4096  largest accepted word count N; must be <= 2**ADDR_W
//  TIMEOUT_CYC 0     idle cycles allowed between accepted bytes while loading; 0 = no timeout
// PORTS
//  CLK        in   1       system clock; all state changes on the rising edge
//  reset      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse; begins a load from IDLE, DONE or ERROR
//  rx_data    in   8       incoming byte
//  rx_valid   in   1       rx_data is valid
//  rx_ready   out  1       loader can accept a byte; a byte transfers on an edge where valid&&ready
//  mem_addr   out  ADDR_W  word address to instruction memory
//  mem_din    out  16      word to instruction memory
//  mem_we     out  1       write enable, 1-cycle pulse per word
//  cpu_reset  out  1       active-high reset to the processor
//  done       out  1       load completed with a good checksum
//  error      out  1       load failed (bad length, bad checksum or timeout)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, rx_ready=0, mem_addr=0, mem_din=0, mem_we=0,
//   cpu_reset=1, done=0, error=0. Counters and checksum are cleared.
//  Frame: LEN_HI, LEN_LO (N, big-endian), then N x {DATA_HI, DATA_LO}, then CHK.
//   CHK = XOR of every preceding byte in the frame, including both length bytes.
//  States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
//   IDLE --start--> LEN_HI. On this transition: cpu_reset=1, done=0, error=0, checksum=0,
//    word index k=0.
//   LEN_HI --accept--> LEN_LO.
//   LEN_LO --accept--> DATA_HI if 1<=N<=MAX_WORDS; CHECK if N=0; ERROR if N>MAX_WORDS.
//   DATA_HI --accept--> DATA_LO. The high byte is latched.
//   DATA_LO --accept--> DATA_HI if k+1<N, otherwise CHECK. On the same edge, mem_din={hi,lo},
//    mem_addr=k and mem_we=1. mem_we drops on the next edge, so it is high for exactly 1 cycle.
//    k then increments.
//   CHECK --accept--> DONE if byte==checksum, otherwise ERROR.
//   DONE: done=1, cpu_reset=0. ERROR: error=1, cpu_reset=1. Both hold until start -> LEN_HI.
//  rx_ready=1 exactly in LEN_HI..CHECK, including the cycle mem_we is high (no write stall).
//   rx_ready=0 in IDLE, DONE and ERROR.
//  start is ignored while in LEN_HI..CHECK.
//  Latency: mem_we is visible the cycle after the accepting edge of the low byte. done/error
//   are visible the cycle after the CHK byte is accepted.
//  mem_addr and mem_din hold their last values when mem_we=0. There is no wrap: k never
//   exceeds MAX_WORDS-1.
//  Timeout (TIMEOUT_CYC>0): the counter clears on start and on every accept, and counts every
//   other cycle in LEN_HI..CHECK. When it reaches TIMEOUT_CYC the state goes to ERROR.
//  Words already written are never rolled back. Async reset mid-load aborts the load
//   immediately and the memory is left partially written.
// TESTING
//  1 start; bytes 00 03 12 34 AB CD 00 01 42 -> writes (0,1234),(1,ABCD),(2,0001); done=1, cpu_reset=0
//  2 same frame but CHK=43 -> three writes still occur; error=1, done=0, cpu_reset=1
//  3 bytes 00 00 00 -> no mem_we; done=1; bytes 00 00 01 -> error=1
//  4 length 10 01 (N=4097) -> error=1 on the cycle after LEN_LO; rx_ready=0; no mem_we
//  5 frame 1 with rx_valid toggled randomly, plus start pulsed mid-load -> same result as 1;
//    start has no effect
//  6 TIMEOUT_CYC=100, send 00 01 12 then stall -> error=1 exactly 100 cycles after the last accept;
//    reset=0 mid-frame -> all outputs return to reset values; a new start with frame 1 -> done=1

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader for the instruction memory write port
module program_loader #(
    parameter int ADDR_W      = 12,
    parameter int MAX_WORDS   = 4096,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [7:0]         len_hi;
    logic [15:0]        len;
    logic [7:0]         data_hi;
    logic [ADDR_W-1:0]  k;
    logic [7:0]         csum;
    logic [31:0]        tcnt;

    logic               loading;
    logic               accept;
    logic               start_ok;
    logic [15:0]        n_word;
    logic               n_zero;
    logic               n_over;
    logic               last_word;
    logic               timeout_hit;

    // The byte link is only open while a frame is in progress; status outputs are
    // decoded straight from the state so they change on the same edge as the state.
    assign loading   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI)
                    || (state == S_DATA_LO) || (state == S_CHECK);
    assign rx_ready  = loading;
    assign accept    = rx_valid && loading;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);
    assign cpu_reset = (state != S_DONE);

    assign n_word    = {len_hi, rx_data};
    assign n_zero    = (n_word == 16'd0);
    assign n_over    = (32'(n_word) > 32'(MAX_WORDS));
    assign last_word = ((32'(k) + 32'd1) >= 32'(len));

    // Timeout fires on the idle cycle that would bring the gap to TIMEOUT_CYC.
    always_comb begin
        timeout_hit = 1'b0;
        if ((TIMEOUT_CYC > 0) && loading && !accept && (tcnt == 32'(TIMEOUT_CYC - 1))) begin
            timeout_hit = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: frame parsing, length/checksum verdicts and timeout abort.
    always_comb begin
        state_nx = state;
        if (timeout_hit) begin
            state_nx = S_ERROR;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) state_nx = S_LEN_HI;
                end
                S_LEN_HI: begin
                    if (accept) state_nx = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if (n_zero)      state_nx = S_CHECK;
                        else if (n_over) state_nx = S_ERROR;
                        else             state_nx = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (accept) state_nx = S_DATA_LO;
                end
                S_DATA_LO: begin
                    if (accept) state_nx = last_word ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    if (accept) state_nx = (rx_data == csum) ? S_DONE : S_ERROR;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Datapath: length capture, word assembly, memory write pulse, checksum and gap counter.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            len_hi   <= 8'd0;
            len      <= 16'd0;
            data_hi  <= 8'd0;
            k        <= '0;
            csum     <= 8'd0;
            tcnt     <= 32'd0;
            mem_addr <= '0;
            mem_din  <= 16'd0;
            mem_we   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                csum <= 8'd0;
                k    <= '0;
                tcnt <= 32'd0;
            end else if (accept) begin
                tcnt <= 32'd0;
                if (state != S_CHECK) begin
                    csum <= csum ^ rx_data;
                end
                case (state)
                    S_LEN_HI:  len_hi  <= rx_data;
                    S_LEN_LO:  len     <= n_word;
                    S_DATA_HI: data_hi <= rx_data;
                    S_DATA_LO: begin
                        mem_we   <= 1'b1;
                        mem_addr <= k;
                        mem_din  <= {data_hi, rx_data};
                        // Hold k on the final word so it never passes MAX_WORDS-1.
                        if (!last_word) begin
                            k <= k + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (loading && (TIMEOUT_CYC > 0)) begin
                tcnt <= tcnt + 32'd1;
            end
        end
    end

endmodule
